// File: rtl/serial_comp_pkg.sv
// rtl/serial_comp_pkg.sv - FSM states, one-hot result encoding for the serial magnitude comparator
package serial_comp_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Result vector layout is {lt, gt, eq}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b100;

    function automatic logic [2:0] pack_res(input logic eq, input logic gt, input logic lt);
        return {lt, gt, eq};
    endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// rtl/comp_bit_cell.sv - combinational 1-bit magnitude compare cell
module comp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic eq,
    output logic gt,
    output logic lt
);

    assign eq = ~(a_bit ^ b_bit);
    assign gt = a_bit & ~b_bit;
    assign lt = ~a_bit & b_bit;

endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first magnitude comparator; SERIAL_COMP_SIGNED_EN selects two's complement
module serial_mag_comp
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic a_bit,
    input  logic b_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic equal,
    output logic greater,
    output logic lower,
    output logic busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [2:0]    acc;
    logic [2:0]    res;
    logic          beat;
    logic          cell_eq;
    logic          cell_gt;
    logic          cell_lt;
    logic [2:0]    beat_res;
    logic [2:0]    nxt_acc;

    comp_bit_cell u_cell (
        .a_bit (a_bit),
        .b_bit (b_bit),
        .eq    (cell_eq),
        .gt    (cell_gt),
        .lt    (cell_lt)
    );

`ifdef SERIAL_COMP_SIGNED_EN
    // The first beat carries the sign bit, where a set bit means the smaller value.
    assign beat_res = (count == CNT_LOAD) ? pack_res(cell_eq, cell_lt, cell_gt)
                                          : pack_res(cell_eq, cell_gt, cell_lt);
`else
    assign beat_res = pack_res(cell_eq, cell_gt, cell_lt);
`endif

    // acc stays RES_EQ until the first differing bit pair; after that it is frozen.
    assign nxt_acc = (acc == RES_EQ) ? beat_res : acc;

    assign beat      = in_valid & in_ready;
    assign in_ready  = (state == SHIFT);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign equal     = res[0];
    assign greater   = res[1];
    assign lower     = res[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            acc   <= RES_EQ;
            res   <= RES_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        count <= CNT_LOAD;
                        acc   <= RES_EQ;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        acc   <= nxt_acc;
                        count <= count - CW'(1);
                        if (count == '0) begin
                            state <= DONE;
                            res   <= nxt_acc;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        res   <= RES_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    res   <= RES_NONE;
                end
            endcase
        end
    end

endmodule
